// File: rtl/crcu_pkg.sv
// crcu_pkg: shared register offsets, field positions and APB slave state type for CRCU register blocks
package crcu_pkg;
  localparam int RST_CTL_OFS = 'h00;
  localparam int RST_STATUS_OFS = 'h04;
  localparam int RST_CNT_CLR_OFS = 'h08;
  localparam int RST_EN_BIT = 0;
  localparam int SW_RST_REQ_BIT = 1;
  localparam int RST_DUR_LSB = 3;
  localparam int RST_DUR_MSB = 18;
  localparam logic [31:0] SW_RST_REQ_MASK = 32'd1 << SW_RST_REQ_BIT;
  localparam logic [31:0] RST_CTL_WMASK = ((32'd1 << (RST_DUR_MSB + 1)) - (32'd1 << RST_DUR_LSB))
                                          | SW_RST_REQ_MASK | (32'd1 << RST_EN_BIT);
  localparam logic [31:0] RST_CTL_RMASK = RST_CTL_WMASK & ~SW_RST_REQ_MASK;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, WAIT} apb_state_e;
endpackage

// File: rtl/crcu_apb_slv_fsm.sv
// crcu_apb_slv_fsm: APB slave handshake FSM with a 3-bit wait-state counter and registered PREADY
module crcu_apb_slv_fsm import crcu_pkg::*; #(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic ready_set
);
  localparam logic [2:0] WS = 3'(WAIT_STATES);
  apb_state_e state;
  logic [2:0] cnt;
  // ready_set marks the edge that opens the single PREADY cycle
  assign ready_set = psel && (state == SETUP ? WS == 3'd0
                                             : (state == ACCESS || state == WAIT) && !pready && cnt == 3'd1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 3'd0;
      pready <= 1'b0;
    end else begin
      pready <= ready_set;
      if (!psel) state <= IDLE;
      else if (state == IDLE) state <= penable ? IDLE : SETUP;
      else if (state == SETUP) begin
        state <= ACCESS;
        cnt <= WS;
      end else begin
        state <= pready ? IDLE : WAIT;
        cnt <= cnt - 3'd1;
      end
    end
  end
endmodule

// File: rtl/crcu_rst_ctl_apb_regs.sv
// crcu_rst_ctl_apb_regs: APB register block owning the reset-control word, with reset status,
// saturating reset-event counter and write protection while the looped-back reset is active
module crcu_rst_ctl_apb_regs import crcu_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [15:0] RST_DUR_DEFAULT = 16'd16
) (
  input  logic              CRCU_CLK,
  input  logic              CRCU_RST,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              rst_obs,
  output logic [31:0]       rst_ctl_reg
);
  logic [ADDR_W-1:0] ofs;
  logic is_ctl, is_sts, is_clr, rd_err, wr, rise, ready_set, rst_obs_q;
  logic [15:0] rst_count;
  logic [31:0] rd_data;
  crcu_apb_slv_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .clk(CRCU_CLK),
    .rst(CRCU_RST),
    .psel(PSEL),
    .penable(PENABLE),
    .pready(PREADY),
    .ready_set(ready_set)
  );
  always_comb begin
    ofs = PADDR & ~ADDR_W'(3);
    is_ctl = ofs == ADDR_W'(RST_CTL_OFS);
    is_sts = ofs == ADDR_W'(RST_STATUS_OFS);
    is_clr = ofs == ADDR_W'(RST_CNT_CLR_OFS);
    rd_data = is_ctl ? rst_ctl_reg & RST_CTL_RMASK : is_sts ? {rst_count, 15'd0, rst_obs_q} : 32'd0;
    rd_err = !(is_ctl || is_sts || is_clr) || (is_ctl && PWRITE && rst_obs_q);
    wr = PREADY && PSEL && PENABLE && PWRITE;
    rise = rst_obs && !rst_obs_q;
  end
  // PSLVERR held from the ready edge tells the commit whether this RST_CTL write was protected
  always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
    if (CRCU_RST) begin
      rst_ctl_reg <= 32'(RST_DUR_DEFAULT) << RST_DUR_LSB;
      PRDATA <= 32'd0;
      PSLVERR <= 1'b0;
      rst_count <= 16'd0;
      rst_obs_q <= 1'b0;
    end else begin
      rst_obs_q <= rst_obs;
      PRDATA <= (ready_set && !PWRITE) ? rd_data : 32'd0;
      PSLVERR <= ready_set && rd_err;
      rst_count <= (wr && is_clr && PWDATA[0]) ? 16'd0
                 : (rise && rst_count != 16'hFFFF) ? rst_count + 16'd1 : rst_count;
      rst_ctl_reg <= !(wr && is_ctl) ? rst_ctl_reg & ~SW_RST_REQ_MASK
                   : PSLVERR ? {rst_ctl_reg[31:1], PWDATA[0]} & ~SW_RST_REQ_MASK
                   : PWDATA & RST_CTL_WMASK;
    end
  end
endmodule

// File: tb/tb_crcu_rst_ctl_apb_regs.sv
// tb_crcu_rst_ctl_apb_regs: directed APB stimulus against a zero-wait and a three-wait instance
module tb_crcu_rst_ctl_apb_regs;
  logic clk, rst, penable, pwrite, psel0, psel3, rst_obs;
  logic [7:0] paddr;
  logic [31:0] pwdata, prdata0, prdata3, rst_ctl0, rst_ctl3;
  logic pready0, pready3, pslverr0, pslverr3;
  int total = 0;
  int bad = 0;

  crcu_rst_ctl_apb_regs #(.ADDR_W(8), .WAIT_STATES(0), .RST_DUR_DEFAULT(16'd16)) dut0 (
    .CRCU_CLK(clk), .CRCU_RST(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0),
    .rst_obs(rst_obs), .rst_ctl_reg(rst_ctl0));

  crcu_rst_ctl_apb_regs #(.ADDR_W(8), .WAIT_STATES(3), .RST_DUR_DEFAULT(16'd16)) dut3 (
    .CRCU_CLK(clk), .CRCU_RST(rst), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3),
    .rst_obs(rst_obs), .rst_ctl_reg(rst_ctl3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb(input bit w3, input bit wr, input logic [7:0] a, input logic [31:0] d,
                     input bit obs_at_ready, output logic [31:0] rd, output logic err, output int waits);
    @(negedge clk);
    psel0 = !w3;
    psel3 = w3;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    while (!(w3 ? pready3 : pready0) && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    rd = w3 ? prdata3 : prdata0;
    err = w3 ? pslverr3 : pslverr0;
    if (obs_at_ready) rst_obs = 1'b1;
    @(posedge clk);
    #1;
    psel0 = 1'b0;
    psel3 = 1'b0;
    penable = 1'b0;
  endtask

  task automatic do_wr(input string tag, input bit w3, input logic [7:0] a, input logic [31:0] d,
                       input logic exp_err, input int exp_waits, input bit obs_at_ready = 1'b0);
    logic [31:0] rd;
    logic err;
    int waits;
    apb(w3, 1'b1, a, d, obs_at_ready, rd, err, waits);
    chk({tag, " pslverr"}, 32'(err), 32'(exp_err));
    chk({tag, " waits"}, 32'(waits), 32'(exp_waits));
  endtask

  task automatic do_rd(input string tag, input bit w3, input logic [7:0] a, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_waits);
    logic [31:0] rd;
    logic err;
    int waits;
    apb(w3, 1'b0, a, 32'd0, 1'b0, rd, err, waits);
    chk({tag, " prdata"}, rd, exp_rd);
    chk({tag, " pslverr"}, 32'(err), 32'(exp_err));
    chk({tag, " waits"}, 32'(waits), 32'(exp_waits));
  endtask

  task automatic pulse_obs(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) rst_obs = 1'b1;
      @(negedge clk);
      @(negedge clk) rst_obs = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    {penable, pwrite, psel0, psel3, rst_obs} = '0;
    paddr = '0;
    pwdata = '0;
    repeat (3) @(negedge clk);
    chk("rst pready", 32'(pready0), 32'd0);
    chk("rst pslverr", 32'(pslverr0), 32'd0);
    chk("rst prdata", prdata0, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst ctl", rst_ctl0, 32'h0000_0080);
    do_rd("rd status init", 1'b0, 8'h04, 32'd0, 1'b0, 1);
    do_wr("wr ctl 191", 1'b0, 8'h00, 32'h0000_0191, 1'b0, 1);
    chk("ctl after 191", rst_ctl0, 32'h0000_0191);
    do_rd("rd ctl 191", 1'b0, 8'h00, 32'h0000_0191, 1'b0, 1);
    do_wr("wr ctl ones", 1'b0, 8'h00, 32'hFFFF_FFFF, 1'b0, 1);
    chk("ctl after ones", rst_ctl0, 32'h0007_FFFB);
    do_rd("rd ctl ones", 1'b0, 8'h00, 32'h0007_FFF9, 1'b0, 1);
    do_wr("wr ctl 3", 1'b0, 8'h00, 32'h0000_0003, 1'b0, 1);
    chk("sw req high", rst_ctl0, 32'h0000_0003);
    @(posedge clk);
    #1;
    chk("sw req cleared", rst_ctl0, 32'h0000_0001);
    do_rd("rd ctl 3", 1'b0, 8'h00, 32'h0000_0001, 1'b0, 1);
    do_wr("wr bad ofs", 1'b0, 8'h0C, 32'hDEAD_BEEF, 1'b1, 1);
    chk("ctl after bad wr", rst_ctl0, 32'h0000_0001);
    do_rd("rd bad ofs", 1'b0, 8'h0C, 32'd0, 1'b1, 1);
    pulse_obs(3);
    do_rd("rd count 3", 1'b0, 8'h04, 32'h0003_0000, 1'b0, 1);
    do_wr("clr with edge", 1'b0, 8'h08, 32'h0000_0001, 1'b0, 1, 1'b1);
    do_rd("rd after clr", 1'b0, 8'h04, 32'h0000_0001, 1'b0, 1);
    do_rd("rd cnt_clr", 1'b0, 8'h08, 32'd0, 1'b0, 1);
    rst_obs = 1'b0;
    repeat (2) @(negedge clk);
    do_wr("wr ctl 191 again", 1'b0, 8'h00, 32'h0000_0191, 1'b0, 1);
    rst_obs = 1'b1;
    repeat (2) @(negedge clk);
    do_wr("protected wr", 1'b0, 8'h00, 32'h0000_0050, 1'b1, 1);
    chk("ctl protected", rst_ctl0, 32'h0000_0190);
    do_rd("rd ctl protected", 1'b0, 8'h00, 32'h0000_0190, 1'b0, 1);
    rst_obs = 1'b0;
    repeat (2) @(negedge clk);
    force dut0.rst_count = 16'hFFFE;
    @(negedge clk);
    release dut0.rst_count;
    pulse_obs(3);
    do_rd("rd count sat", 1'b0, 8'h04, 32'hFFFF_0000, 1'b0, 1);
    do_rd("ws3 bad ofs", 1'b1, 8'h0C, 32'd0, 1'b1, 4);
    do_wr("ws3 wr ctl", 1'b1, 8'h00, 32'h0000_0191, 1'b0, 4);
    chk("ws3 ctl", rst_ctl3, 32'h0000_0191);
    @(negedge clk);
    {psel3, pwrite, penable} = 3'b110;
    paddr = 8'h00;
    pwdata = 32'h0000_0050;
    @(negedge clk) penable = 1'b1;
    repeat (2) @(negedge clk);
    {psel3, penable} = 2'b00;
    repeat (6) @(negedge clk);
    chk("psel drop ctl", rst_ctl3, 32'h0000_0191);
    chk("psel drop pready", 32'(pready3), 32'd0);
    do_rd("ws3 rd after drop", 1'b1, 8'h00, 32'h0000_0191, 1'b0, 4);
    @(negedge clk);
    {psel3, pwrite, penable} = 3'b110;
    @(negedge clk) penable = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst ctl3", rst_ctl3, 32'h0000_0080);
    chk("mid rst pready3", 32'(pready3), 32'd0);
    chk("mid rst ctl0", rst_ctl0, 32'h0000_0080);
    @(negedge clk);
    {psel3, penable} = 2'b00;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post rst ctl3", rst_ctl3, 32'h0000_0080);
    do_rd("ws3 rd after rst", 1'b1, 8'h00, 32'h0000_0080, 1'b0, 4);
    do_rd("rd count after rst", 1'b0, 8'h04, 32'd0, 1'b0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
